mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-side and data-side cache refill/write paths of the Riscv151 core.
- Accepts one request at a time from each side.
- Grants by priority: data side first, with an instruction-side anti-starvation override.
- Sequences the memory handshake, counts read-burst beats, and returns responses to the granted requester.
- Drives a stall output back to the pipeline while any requester is pending.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-side and D-side
// refill/write paths. D-side has priority unless the I-side has been passed
// over STARVE_LIMIT times in a row. Read bursts are BEATS words long; writes
// are a single word acknowledged by one response beat.
module mem_arbiter #(
    parameter int BEATS        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_req_ready,
    output logic        ic_resp_valid,
    output logic [31:0] ic_resp_data,
    output logic        ic_resp_last,

    input  logic        dc_req_valid,
    input  logic [31:0] dc_req_addr,
    input  logic [3:0]  dc_req_we,
    input  logic [31:0] dc_req_wdata,
    output logic        dc_req_ready,
    output logic        dc_resp_valid,
    output logic [31:0] dc_resp_data,
    output logic        dc_resp_last,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,

    output logic        stall
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int LW = $clog2(BEATS) + 2;
    localparam logic [31:0]   LINE_MASK  = ~((32'd1 << LW) - 32'd1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          r_grant_dc;
    logic [31:0]   r_addr;
    logic [3:0]    r_we;
    logic [31:0]   r_wdata;
    logic [BW-1:0] r_beat;
    logic [SW-1:0] r_starve;

    logic          w_any_req;
    logic          w_pick_dc;
    logic          w_is_write;
    logic          w_last;

    assign w_any_req  = ic_req_valid | dc_req_valid;
    // I-side wins only when it has been starved for STARVE_LIMIT D grants
    assign w_pick_dc  = dc_req_valid & ~(ic_req_valid & (r_starve == STARVE_MAX));
    assign w_is_write = |r_we;
    // A write finishes on its single ack; a read on its final burst beat
    assign w_last     = w_is_write | (r_beat == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept, hold request until taken, drain responses
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)                 w_state_next = S_ISSUE;
            S_ISSUE: if (mem_req_ready)             w_state_next = S_RESP;
            S_RESP:  if (mem_resp_valid && w_last)  w_state_next = S_IDLE;
            default:                                w_state_next = S_IDLE;
        endcase
    end

    // Latch the winning request and track burst beats
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant_dc <= 1'b0;
            r_addr     <= 32'd0;
            r_we       <= 4'd0;
            r_wdata    <= 32'd0;
            r_beat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (w_any_req) begin
                        r_grant_dc <= w_pick_dc;
                        r_addr     <= w_pick_dc ? dc_req_addr  : ic_req_addr;
                        r_we       <= w_pick_dc ? dc_req_we    : 4'd0;
                        r_wdata    <= w_pick_dc ? dc_req_wdata : 32'd0;
                    end
                end
                S_ISSUE: r_beat <= '0;
                S_RESP: begin
                    // Never step past the last beat; IDLE clears it for the next burst
                    if (mem_resp_valid && !w_last) begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                default: r_beat <= '0;
            endcase
        end
    end

    // Count consecutive D grants that bypassed a waiting I-side request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            if (!w_pick_dc) begin
                r_starve <= '0;
            end else if (ic_req_valid && r_starve != STARVE_MAX) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // Outputs: everything forced low while reset is asserted
    always_comb begin
        ic_req_ready  = 1'b0;
        ic_resp_valid = 1'b0;
        ic_resp_data  = 32'd0;
        ic_resp_last  = 1'b0;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        dc_resp_data  = 32'd0;
        dc_resp_last  = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = 32'd0;
        mem_req_we    = 4'd0;
        mem_req_wdata = 32'd0;
        stall         = 1'b0;
        if (reset) begin
            stall = w_any_req | (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    dc_req_ready = w_pick_dc;
                    ic_req_ready = ic_req_valid & ~w_pick_dc;
                end
                S_ISSUE: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = w_is_write ? {r_addr[31:2], 2'b00} : (r_addr & LINE_MASK);
                    mem_req_we    = r_we;
                    mem_req_wdata = r_wdata;
                end
                S_RESP: begin
                    if (mem_resp_valid) begin
                        if (r_grant_dc) begin
                            dc_resp_valid = 1'b1;
                            dc_resp_data  = w_is_write ? 32'd0 : mem_resp_data;
                            dc_resp_last  = w_last;
                        end else begin
                            ic_resp_valid = 1'b1;
                            ic_resp_data  = mem_resp_data;
                            ic_resp_last  = w_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected response beats into
// a queue, a negedge monitor pops and compares each beat the DUT presents.
module tb_mem_arbiter;

    localparam int BEATS = 4;

    logic        clk;
    logic        reset;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic        ic_resp_last;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic [3:0]  dc_req_we;
    logic [31:0] dc_req_wdata;
    logic        dc_req_ready;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_data;
    logic        dc_resp_last;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall;

    mem_arbiter #(.BEATS(BEATS), .STARVE_LIMIT(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .ic_req_valid  (ic_req_valid),
        .ic_req_addr   (ic_req_addr),
        .ic_req_ready  (ic_req_ready),
        .ic_resp_valid (ic_resp_valid),
        .ic_resp_data  (ic_resp_data),
        .ic_resp_last  (ic_resp_last),
        .dc_req_valid  (dc_req_valid),
        .dc_req_addr   (dc_req_addr),
        .dc_req_we     (dc_req_we),
        .dc_req_wdata  (dc_req_wdata),
        .dc_req_ready  (dc_req_ready),
        .dc_resp_valid (dc_resp_valid),
        .dc_resp_data  (dc_resp_data),
        .dc_resp_last  (dc_resp_last),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .stall         (stall)
    );

    typedef struct {
        bit          dc;
        logic [31:0] data;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs_high();
        return $countones({ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
                           dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
                           mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, stall});
    endfunction

    // Called at the first ISSUE cycle; returns in the following IDLE cycle.
    task automatic serve(input bit is_dc, input bit is_wr, input logic [31:0] ea,
                         input logic [3:0] ewe, input logic [31:0] ewd,
                         input int dly, input logic [31:0] d0);
        int nb;
        for (int k = 0; k <= dly; k++) begin
            if (k > 0) cyc();
            mem_req_ready = (k == dly);
            #2;
            chk("issue_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("issue_addr", mem_req_addr, ea);
            chk("issue_we", {28'd0, mem_req_we}, {28'd0, ewe});
            if (is_wr) chk("issue_wdata", mem_req_wdata, ewd);
        end
        cyc();
        mem_req_ready = 1'b0;
        nb = is_wr ? 1 : BEATS;
        for (int b = 0; b < nb; b++) begin
            if (b > 0) cyc();
            mem_resp_valid = 1'b1;
            mem_resp_data  = d0 + 32'(b);
            q.push_back('{dc: is_dc, data: (is_wr ? 32'd0 : d0 + 32'(b)), last: (b == nb - 1)});
        end
        cyc();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (ic_resp_valid || dc_resp_valid) begin
            n_cmp++;
            if (ic_resp_valid && dc_resp_valid) begin
                n_bad++;
                $display("FAIL resp_both: ic and dc resp_valid together at %0t", $time);
            end else if (q.size() == 0) begin
                n_bad++;
                $display("FAIL resp_unexpected: dc=%0b data=0x%08h, want no beat at %0t",
                         dc_resp_valid, dc_resp_valid ? dc_resp_data : ic_resp_data, $time);
            end else begin
                exp_t e;
                bit          a_dc;
                logic [31:0] a_data;
                logic        a_last;
                e      = q.pop_front();
                a_dc   = dc_resp_valid;
                a_data = a_dc ? dc_resp_data : ic_resp_data;
                a_last = a_dc ? dc_resp_last : ic_resp_last;
                if (a_dc !== e.dc || a_data !== e.data || a_last !== e.last) begin
                    n_bad++;
                    $display("FAIL resp_beat: got dc=%0b data=0x%08h last=%0b want dc=%0b data=0x%08h last=%0b",
                             a_dc, a_data, a_last, e.dc, e.data, e.last);
                end else begin
                    $display("ok   resp_beat: dc=%0b data=0x%08h last=%0b", a_dc, a_data, a_last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        ic_req_valid   = 1'b0;
        ic_req_addr    = 32'd0;
        dc_req_valid   = 1'b0;
        dc_req_addr    = 32'd0;
        dc_req_we      = 4'd0;
        dc_req_wdata   = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;

        // Reset: all outputs low even with a request pending
        cyc();
        dc_req_valid = 1'b1;
        #2;
        chk("rst_outs_high", 32'(outs_high()), 32'd0);
        cyc();
        dc_req_valid = 1'b0;
        reset = 1'b1;

        // Idle bus: stray responses ignored, no stall
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_resp_valid = (i != 1);
            mem_resp_data  = 32'h77;
            #2;
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_memreq", {31'd0, mem_req_valid}, 32'd0);
        end
        cyc();
        mem_resp_valid = 1'b0;

        // I-side read burst
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_1234;
        #2;
        chk("ird_ic_ready", {31'd0, ic_req_ready}, 32'd1);
        chk("ird_dc_ready", {31'd0, dc_req_ready}, 32'd0);
        cyc();
        ic_req_valid = 1'b0;
        #1;
        chk("ird_ready_pulse", {31'd0, ic_req_ready}, 32'd0);
        chk("ird_stall", {31'd0, stall}, 32'd1);
        serve(1'b0, 1'b0, 32'h0000_1230, 4'd0, 32'd0, 0, 32'hA0);
        #2;
        chk("ird_done_stall", {31'd0, stall}, 32'd0);

        // Simultaneous requests: D first, then I
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_0104;
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_0208;
        dc_req_we    = 4'd0;
        #2;
        chk("sim_dc_ready", {31'd0, dc_req_ready}, 32'd1);
        chk("sim_ic_ready", {31'd0, ic_req_ready}, 32'd0);
        cyc();
        dc_req_valid = 1'b0;
        serve(1'b1, 1'b0, 32'h0000_0200, 4'd0, 32'd0, 1, 32'hB0);
        #2;
        chk("sim_ic_next", {31'd0, ic_req_ready}, 32'd1);
        cyc();
        ic_req_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h0000_0100, 4'd0, 32'd0, 0, 32'hC0);

        // D-side write with memory back-pressure
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_2006;
        dc_req_we    = 4'b1100;
        dc_req_wdata = 32'hDEAD_BEEF;
        #2;
        chk("wr_dc_ready", {31'd0, dc_req_ready}, 32'd1);
        cyc();
        dc_req_valid = 1'b0;
        serve(1'b1, 1'b1, 32'h0000_2004, 4'b1100, 32'hDEAD_BEEF, 3, 32'h55);

        // Starvation: three D grants, then I wins
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_3000;
        for (int r = 0; r < 3; r++) begin
            dc_req_valid = 1'b1;
            dc_req_addr  = 32'h0000_0400 + 32'(r * 4);
            dc_req_we    = 4'b0001;
            dc_req_wdata = 32'(r + 1);
            #2;
            chk("stv_dc_win", {31'd0, dc_req_ready}, 32'd1);
            chk("stv_ic_wait", {31'd0, ic_req_ready}, 32'd0);
            cyc();
            dc_req_valid = 1'b0;
            serve(1'b1, 1'b1, 32'h0000_0400 + 32'(r * 4), 4'b0001, 32'(r + 1), 0, 32'h0);
        end
        dc_req_valid = 1'b1;
        dc_req_addr  = 32'h0000_0500;
        dc_req_we    = 4'b1111;
        dc_req_wdata = 32'h1234_5678;
        #2;
        chk("stv_ic_win", {31'd0, ic_req_ready}, 32'd1);
        chk("stv_dc_lose", {31'd0, dc_req_ready}, 32'd0);
        cyc();
        serve(1'b0, 1'b0, 32'h0000_3000, 4'd0, 32'd0, 0, 32'hD0);
        // Counter cleared: with both valid, D wins again
        #2;
        chk("stv_cleared", {31'd0, dc_req_ready}, 32'd1);
        cyc();
        dc_req_valid = 1'b0;
        serve(1'b1, 1'b1, 32'h0000_0500, 4'b1111, 32'h1234_5678, 0, 32'h0);
        #2;
        chk("stv_ic_after", {31'd0, ic_req_ready}, 32'd1);
        cyc();
        ic_req_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h0000_3000, 4'd0, 32'd0, 0, 32'hE0);

        // Reset during RESP beat 2
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_5000;
        #2;
        chk("rr_ic_ready", {31'd0, ic_req_ready}, 32'd1);
        cyc();
        ic_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hF0;
        q.push_back('{dc: 1'b0, data: 32'hF0, last: 1'b0});
        cyc();
        mem_resp_data  = 32'hF1;
        q.push_back('{dc: 1'b0, data: 32'hF1, last: 1'b0});
        cyc();
        mem_resp_data  = 32'hF2;
        reset = 1'b0;
        #2;
        chk("rr_async_outs", 32'(outs_high()), 32'd0);
        cyc();
        reset = 1'b1;
        #2;
        chk("rr_stray_ic", {31'd0, ic_resp_valid}, 32'd0);
        chk("rr_stray_dc", {31'd0, dc_resp_valid}, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd0);
        cyc();
        mem_resp_valid = 1'b0;
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h0000_6004;
        #2;
        chk("rr_next_ready", {31'd0, ic_req_ready}, 32'd1);
        cyc();
        ic_req_valid = 1'b0;
        serve(1'b0, 1'b0, 32'h0000_6000, 4'd0, 32'd0, 0, 32'h90);

        cyc();
        cyc();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
